vector_mem_arbiter: RTL and testbench

VECTOR_MEM_ARBITER -- requirements
Module: vector_mem_arbiter

---
 rtl/vector_mem_arbiter_pkg.sv | 35 +++
 rtl/vector_mem_arbiter_rr_arbiter.sv | 33 +++
 rtl/vector_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_vector_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_mem_arbiter_pkg.sv
// Shared types for the vector memory arbiter: request beat layout,
// request kinds and the arbiter FSM state encoding.
package vector_mem_arbiter_pkg;

  localparam int VECTOR_REG_DEPTH = 64;

  localparam int CORE_W = 3;
  localparam int AID_W  = 4;
  localparam int LEN_W  = 7;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;

  localparam logic READ_REQ  = 1'b0;
  localparam logic WRITE_REQ = 1'b1;

  // One request/response beat. access_length is only interpreted on the
  // first beat of a transfer; later beats of a burst carry it unchanged.
  typedef struct packed {
    logic              vld;
    logic [CORE_W-1:0] core_id;
    logic [AID_W-1:0]  access_id;
    logic              req_type;
    logic [LEN_W-1:0]  access_length;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   byte_en;
  } request_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vector_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester found
// after ptr_i, wrapping modulo NUM_PORTS.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PW-1:0]        ptr_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [PW-1:0]        idx_o,
  output logic                 any_o
);

  // Scan ptr+1 .. ptr+NUM_PORTS so the last winner has lowest priority.
  always_comb begin
    logic [PW-1:0] cand;
    logic          found;
    cand    = '0;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(ptr_i) + i) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        grant_o[cand]  = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/vector_mem_arbiter.sv
// Arbitrates NUM_PORTS load/store units onto one memory request channel,
// locking the channel to one port for the duration of a burst, and routes
// memory responses back to the issuing port by core_id.
//
// Handshake: a port beat is consumed in the cycle its port_grant bit is high
// (grant implies the beat had vld). mem_req is a registered valid/ready
// source: a beat with mem_req.vld is held stable until mem_ready is seen
// high, and a new beat may load in that same cycle. Responses have no
// backpressure.
module vector_mem_arbiter
  import vector_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_BURST = VECTOR_REG_DEPTH,
  localparam int PW       = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  request_t             port_req [NUM_PORTS],
  output logic [NUM_PORTS-1:0] port_grant,
  output request_t             port_rsp [NUM_PORTS],
  output request_t             mem_req,
  input  logic                 mem_ready,
  input  request_t             mem_rsp,
  output logic [PW-1:0]        owner,
  output logic                 busy
);

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t           state_q;
  logic [PW-1:0]        rr_ptr_q;
  logic [PW-1:0]        owner_q;
  logic [BW-1:0]        beats_left_q;
  request_t             mem_req_q;
  request_t             port_rsp_q [NUM_PORTS];

  logic [NUM_PORTS-1:0] req_vld;
  logic [NUM_PORTS-1:0] arb_grant;
  logic [PW-1:0]        win_idx;
  logic                 arb_any;
  logic                 accept;
  logic                 grant_any;
  logic [PW-1:0]        grant_idx;
  logic [BW-1:0]        eff_len;
  logic [PW-1:0]        rsp_idx;

  assign accept  = !mem_req_q.vld || mem_ready;
  assign rsp_idx = mem_rsp.core_id[PW-1:0];

  // Collect the per-port valid bits for the round-robin picker.
  always_comb begin
    req_vld = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_vld[i] = port_req[i].vld;
    end
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_rr_arbiter (
    .req_i   (req_vld),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (win_idx),
    .any_o   (arb_any)
  );

  // Effective burst length of the candidate first beat: 0 means 1, and
  // anything beyond MAX_BURST is clamped.
  always_comb begin
    eff_len = '0;
    if (port_req[win_idx].access_length == '0) begin
      eff_len = BW'(1);
    end else if (int'(port_req[win_idx].access_length) > MAX_BURST) begin
      eff_len = BW'(MAX_BURST);
    end else begin
      eff_len = BW'(port_req[win_idx].access_length);
    end
  end

  // Grant selection: open arbitration in IDLE, owner-only while locked.
  always_comb begin
    port_grant = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    if (state_q == IDLE) begin
      if (accept && arb_any) begin
        port_grant = arb_grant;
        grant_any  = 1'b1;
        grant_idx  = win_idx;
      end
    end else if (accept && port_req[owner_q].vld) begin
      port_grant[owner_q] = 1'b1;
      grant_any           = 1'b1;
      grant_idx           = owner_q;
    end
  end

  // Burst-lock FSM, output request register and response router.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= PW'(NUM_PORTS - 1);
      owner_q      <= '0;
      beats_left_q <= '0;
      mem_req_q    <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        port_rsp_q[i] <= '0;
      end
    end else begin
      if (grant_any) begin
        mem_req_q <= port_req[grant_idx];
      end else if (mem_ready) begin
        mem_req_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (grant_any) begin
            if (eff_len > BW'(1)) begin
              state_q      <= BURST;
              owner_q      <= grant_idx;
              beats_left_q <= eff_len - BW'(1);
            end else begin
              rr_ptr_q <= grant_idx;
            end
          end
        end
        BURST: begin
          if (grant_any) begin
            if (beats_left_q <= BW'(1)) begin
              state_q      <= IDLE;
              rr_ptr_q     <= owner_q;
              beats_left_q <= '0;
            end else begin
              beats_left_q <= beats_left_q - BW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      for (int i = 0; i < NUM_PORTS; i++) begin
        if (mem_rsp.vld && (rsp_idx == PW'(i))) begin
          port_rsp_q[i] <= mem_rsp;
        end else begin
          port_rsp_q[i] <= '0;
        end
      end
    end
  end

  assign mem_req  = mem_req_q;
  assign port_rsp = port_rsp_q;
  assign owner    = owner_q;
  assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Directed bench for vector_mem_arbiter: per-port beat sources, a memory
// request scoreboard and a response scoreboard fed by the stimulus, plus
// per-cycle logs for grant/busy timing checks.
module tb_vector_mem_arbiter;
  import vector_mem_arbiter_pkg::*;

  localparam int NP   = 4;
  localparam int W    = $bits(request_t);
  localparam int LOGN = 128;
  localparam int SRCN = 80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  request_t          port_req [NP];
  logic [NP-1:0]     port_grant;
  request_t          port_rsp [NP];
  request_t          mem_req;
  logic              mem_ready;
  request_t          mem_rsp;
  logic [1:0]        owner;
  logic              busy;

  vector_mem_arbiter #(
    .NUM_PORTS (NP),
    .MAX_BURST (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .port_req   (port_req),
    .port_grant (port_grant),
    .port_rsp   (port_rsp),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .mem_rsp    (mem_rsp),
    .owner      (owner),
    .busy       (busy)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  logic [W-1:0]   exp_q[$];
  logic [W+1:0]   rsp_q[$];

  request_t       src [NP][SRCN];
  int             src_n [NP];
  int             src_i [NP];
  int             pause_port, pause_lo, pause_hi;
  logic           ready_plan [LOGN];

  logic [NP-1:0]  glog [LOGN];
  logic [NP-1:0]  rlog [LOGN];
  logic           blog [LOGN];
  logic           vlog [LOGN];
  logic [31:0]    alog [LOGN];
  int             n;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic request_t mk_beat(int p, int i, int len, logic typ);
    request_t b;
    b               = '0;
    b.vld           = 1'b1;
    b.core_id       = 3'(p);
    b.access_id     = 4'(i);
    b.req_type      = typ;
    b.access_length = 7'(len);
    b.addr          = 32'(p * 32'h1000 + i * 4);
    b.data          = {32'(p) ^ 32'h5A00_0000, 32'(i) ^ 32'hA5A5_0000};
    b.byte_en       = 8'hFF ^ 8'(i);
    return b;
  endfunction

  // Load nb beats of length len on port p, and queue them as expected memory traffic.
  task automatic add_src(int p, int nb, int len, logic typ, int n_exp);
    for (int i = 0; i < nb; i++) begin
      src[p][src_n[p]] = mk_beat(p, i, len, typ);
      if (i < n_exp) exp_q.push_back(W'(src[p][src_n[p]]));
      src_n[p]++;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W+1:0] r;
    if (!reset) begin
      check("grant_onehot", 128'($countones(port_grant) <= 1), 128'(1));
      if (mem_req.vld && mem_ready) begin
        if (exp_q.size() == 0) begin
          check("mem_req_unexpected", 128'(mem_req), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("mem_req_beat", 128'(mem_req), 128'(e));
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (port_rsp[p].vld) begin
          if (rsp_q.size() == 0) begin
            check("port_rsp_unexpected", 128'({2'(p), port_rsp[p]}), 128'(0));
          end else begin
            r = rsp_q.pop_front();
            check("port_rsp_beat", 128'({2'(p), port_rsp[p]}), 128'(r));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      if (src_i[p] < src_n[p] && !(p == pause_port && n >= pause_lo && n <= pause_hi))
        port_req[p] = src[p][src_i[p]];
      else
        port_req[p] = '0;
    end
    mem_ready = (n < LOGN) ? ready_plan[n] : 1'b1;
  endtask

  task automatic cycle();
    logic [NP-1:0] g;
    @(negedge clk);
    if (n < LOGN) begin
      glog[n] = port_grant;
      blog[n] = busy;
      vlog[n] = mem_req.vld;
      alog[n] = mem_req.addr;
      for (int p = 0; p < NP; p++) rlog[n][p] = port_rsp[p].vld;
    end
    g = port_grant;
    n++;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) if (g[p]) src_i[p]++;
    mem_rsp = '0;
    drive_inputs();
  endtask

  task automatic run(int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic start();
    n = 0;
    drive_inputs();
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || rsp_q.size() != 0) && k < 200) begin
      cycle();
      k++;
    end
    check({name, "_drain"}, 128'(exp_q.size() + rsp_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int p = 0; p < NP; p++) begin
      src_n[p]    = 0;
      src_i[p]    = 0;
      port_req[p] = '0;
    end
    for (int c = 0; c < LOGN; c++) ready_plan[c] = 1'b1;
    pause_port = -1;
    pause_lo   = 0;
    pause_hi   = -1;
    mem_rsp    = '0;
    mem_ready  = 1'b1;
    exp_q.delete();
    rsp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_owner", 128'(owner), 128'(0));
    check("rst_grant", 128'(port_grant), 128'(0));
    for (int p = 0; p < NP; p++) check("rst_port_rsp", 128'(port_rsp[p]), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n = 0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    request_t rsp;

    // Single port, 4-beat read burst.
    do_reset();
    add_src(1, 4, 4, READ_REQ, 4);
    start();
    run(6);
    for (int c = 0; c < 4; c++) check($sformatf("A_grant%0d", c), 128'(glog[c]), 128'(4'b0010));
    check("A_grant_end", 128'(glog[4]), 128'(0));
    check("A_busy0", 128'(blog[0]), 128'(0));
    check("A_busy1", 128'(blog[1]), 128'(1));
    check("A_busy3", 128'(blog[3]), 128'(1));
    check("A_busy4", 128'(blog[4]), 128'(0));
    check("A_vld0", 128'(vlog[0]), 128'(0));
    check("A_vld1", 128'(vlog[1]), 128'(1));
    check("A_vld4", 128'(vlog[4]), 128'(1));
    check("A_vld5", 128'(vlog[5]), 128'(0));
    drain("A");

    // Ports 0 and 2 contend with 3-beat bursts; no interleaving.
    do_reset();
    add_src(0, 3, 3, READ_REQ, 3);
    add_src(2, 3, 3, WRITE_REQ, 3);
    start();
    run(8);
    for (int c = 0; c < 3; c++) check($sformatf("B_p0_grant%0d", c), 128'(glog[c]), 128'(4'b0001));
    for (int c = 3; c < 6; c++) check($sformatf("B_p2_grant%0d", c), 128'(glog[c]), 128'(4'b0100));
    check("B_grant_end", 128'(glog[6]), 128'(0));
    check("B_busy3", 128'(blog[3]), 128'(0));
    check("B_busy4", 128'(blog[4]), 128'(1));
    drain("B");

    // 8-beat burst with memory stalled in cycles 3-5.
    do_reset();
    add_src(0, 8, 8, WRITE_REQ, 8);
    for (int c = 3; c <= 5; c++) ready_plan[c] = 1'b0;
    start();
    run(12);
    check("C_grant2", 128'(glog[2]), 128'(4'b0001));
    check("C_stall3", 128'(glog[3]), 128'(0));
    check("C_stall5", 128'(glog[5]), 128'(0));
    check("C_hold_addr3", 128'(alog[3]), 128'(32'h0000_0008));
    check("C_hold_addr5", 128'(alog[5]), 128'(32'h0000_0008));
    check("C_hold_vld5", 128'(vlog[5]), 128'(1));
    check("C_grant6", 128'(glog[6]), 128'(4'b0001));
    check("C_grant10", 128'(glog[10]), 128'(4'b0001));
    check("C_grant11", 128'(glog[11]), 128'(0));
    drain("C");

    // Owner drops vld mid-burst; port 3 must wait for the lock to release.
    do_reset();
    add_src(0, 5, 5, READ_REQ, 5);
    add_src(3, 1, 1, READ_REQ, 1);
    pause_port = 0;
    pause_lo   = 2;
    pause_hi   = 4;
    start();
    run(10);
    check("D_grant1", 128'(glog[1]), 128'(4'b0001));
    check("D_gap2", 128'(glog[2]), 128'(0));
    check("D_gap4", 128'(glog[4]), 128'(0));
    check("D_busy3", 128'(blog[3]), 128'(1));
    check("D_grant5", 128'(glog[5]), 128'(4'b0001));
    check("D_grant7", 128'(glog[7]), 128'(4'b0001));
    check("D_p3_grant8", 128'(glog[8]), 128'(4'b1000));
    drain("D");

    // Response routing by core_id mod 4, concurrent with a grant.
    do_reset();
    add_src(1, 1, 1, WRITE_REQ, 1);
    start();
    rsp = mk_beat(6, 9, 1, READ_REQ);
    mem_rsp = rsp;
    rsp_q.push_back({2'd2, rsp});
    cycle();
    rsp = mk_beat(3, 2, 1, READ_REQ);
    mem_rsp = rsp;
    rsp_q.push_back({2'd3, rsp});
    run(3);
    check("E_grant0", 128'(glog[0]), 128'(4'b0010));
    check("E_rsp0", 128'(rlog[0]), 128'(0));
    check("E_rsp1", 128'(rlog[1]), 128'(4'b0100));
    check("E_vld1", 128'(vlog[1]), 128'(1));
    check("E_rsp2", 128'(rlog[2]), 128'(4'b1000));
    check("E_rsp3", 128'(rlog[3]), 128'(0));
    drain("E");

    // access_length 0 acts as a single beat; no burst lock.
    do_reset();
    add_src(0, 1, 0, READ_REQ, 1);
    add_src(1, 1, 1, READ_REQ, 1);
    start();
    run(4);
    check("F_grant0", 128'(glog[0]), 128'(4'b0001));
    check("F_grant1", 128'(glog[1]), 128'(4'b0010));
    check("F_busy1", 128'(blog[1]), 128'(0));
    check("F_busy2", 128'(blog[2]), 128'(0));
    drain("F");

    // access_length 100 is clamped to 64 beats, then a fresh burst starts.
    do_reset();
    add_src(2, 66, 100, WRITE_REQ, 66);
    start();
    run(68);
    check("G_grant63", 128'(glog[63]), 128'(4'b0100));
    check("G_busy63", 128'(blog[63]), 128'(1));
    check("G_busy64", 128'(blog[64]), 128'(0));
    check("G_grant64", 128'(glog[64]), 128'(4'b0100));
    check("G_busy65", 128'(blog[65]), 128'(1));
    drain("G");

    // Reset in the middle of a 6-beat burst, then port 0 wins first.
    do_reset();
    add_src(0, 6, 6, READ_REQ, 2);
    start();
    run(3);
    reset = 1'b1;
    #1;
    check("H_rst_mem_req", 128'(mem_req), 128'(0));
    check("H_rst_busy", 128'(busy), 128'(0));
    check("H_consumed", 128'(exp_q.size()), 128'(0));
    do_reset();
    add_src(1, 1, 1, READ_REQ, 0);
    add_src(0, 1, 1, READ_REQ, 1);
    exp_q.push_back(W'(src[1][0]));
    start();
    run(3);
    check("H_first_grant", 128'(glog[0]), 128'(4'b0001));
    check("H_second_grant", 128'(glog[1]), 128'(4'b0010));
    drain("H");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
